// File: rtl/day1_cmd_packer.sv
// ASCII command-line parser feeding the day-1 dial solver: "L68\n" -> {op, 24-bit value}.
// Optional build macro DAY1_PACK_MOD100_EN: values accumulate modulo 100 instead of saturating.
module day1_cmd_packer #(
    parameter bit ACCEPT_COMMA = 1'b1,
    parameter int ERR_CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_byte,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 data_valid,
    output logic [31:0]          data,
    input  logic                 data_ready,
    output logic [31:0]          cmd_count,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 done,
    output logic [1:0]           state
);
    typedef enum logic [1:0] {IDLE = 2'd0, DIGITS = 2'd1, SKIP = 2'd2} state_t;

    state_t      cur, nxt;
    logic [23:0] acc, nxt_acc, acc_step;
    logic [7:0]  op, nxt_op;
    logic        has_digit, nxt_has;
    logic        last_seen;
    logic        load, err;
    logic        accept, drain;
    logic        is_lf, is_cr, is_space, is_comma, is_op, is_digit, is_term;
    logic [3:0]  digit;

    // Handshake: a byte moves on in_valid && in_ready, a word on data_valid && data_ready.
    assign drain    = data_valid && data_ready;
    assign in_ready = !done && !last_seen && !(data_valid && !data_ready);
    assign accept   = in_valid && in_ready;
    assign state    = cur;

    assign is_lf    = (in_byte == 8'h0A);
    assign is_cr    = (in_byte == 8'h0D);
    assign is_space = (in_byte == 8'h20);
    assign is_comma = (in_byte == 8'h2C);
    assign is_op    = (in_byte == 8'h4C) || (in_byte == 8'h52);
    assign is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    assign is_term  = is_lf || is_cr || (ACCEPT_COMMA && is_comma);
    assign digit    = in_byte[3:0];

`ifdef DAY1_PACK_MOD100_EN
    logic [10:0] mod_sum;
    always_comb begin
        mod_sum  = 11'(acc[6:0]) * 11'd10 + 11'(digit);
        acc_step = 24'(mod_sum % 11'd100);
    end
`else
    logic [28:0] wide_sum;
    always_comb begin
        wide_sum = 29'(acc) * 29'd10 + 29'(digit);
        acc_step = (wide_sum > 29'h0FF_FFFF) ? 24'hFF_FFFF : wide_sum[23:0];
    end
`endif

    always_comb begin
        nxt     = cur;
        nxt_acc = acc;
        nxt_op  = op;
        nxt_has = has_digit;
        load    = 1'b0;
        err     = 1'b0;
        if (accept) begin
            case (cur)
                IDLE: begin
                    if (is_op) begin
                        nxt_op  = in_byte;
                        nxt_acc = '0;
                        nxt_has = 1'b0;
                        nxt     = DIGITS;
                    end else if (!(is_lf || is_cr || is_space || is_comma)) begin
                        err = 1'b1;
                        nxt = SKIP;
                    end
                end
                DIGITS: begin
                    if (is_digit) begin
                        nxt_acc = acc_step;
                        nxt_has = 1'b1;
                    end else if (is_term) begin
                        load = has_digit;
                        err  = !has_digit;
                        nxt  = IDLE;
                    end else begin
                        err = 1'b1;
                        nxt = SKIP;
                    end
                end
                SKIP: begin
                    if (is_lf) nxt = IDLE;
                end
                default: nxt = IDLE;
            endcase
            // The final byte leaves a half-built command: treat it as terminated.
            if (in_last && nxt == DIGITS) begin
                load = nxt_has;
                err  = !nxt_has;
                nxt  = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= IDLE;
            acc        <= '0;
            op         <= '0;
            has_digit  <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            cmd_count  <= '0;
            err_count  <= '0;
            last_seen  <= 1'b0;
            done       <= 1'b0;
        end else begin
            cur       <= nxt;
            acc       <= nxt_acc;
            op        <= nxt_op;
            has_digit <= nxt_has;
            if (load) begin
                data       <= {nxt_op, nxt_acc};
                data_valid <= 1'b1;
            end else if (drain) begin
                data_valid <= 1'b0;
            end
            if (drain) cmd_count <= cmd_count + 32'd1;
            if (err && err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
            if (accept && in_last) last_seen <= 1'b1;
            if (last_seen && (!data_valid || drain)) done <= 1'b1;
        end
    end
endmodule
